// File: rtl/fetch_align_unit_if.sv
// Fetch front-end bundle: redirect input, instruction-memory port and decode port.
interface fetch_align_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        compflag;

  // Fetch unit side.
  modport master (
    input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, compflag
  );

  // Environment side: PC control, instruction memory and decode.
  modport slave (
    output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, compflag
  );
endinterface

// File: rtl/fetch_align_unit.sv
// Instruction fetch and realignment: word fetches into a halfword FIFO,
// RVC / 32-bit split at the FIFO head, one instruction per decode handshake.
module fetch_align_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUF_HW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_align_unit_if.master bus
);
  localparam int unsigned PW = $clog2(BUF_HW);
  localparam int unsigned CW = PW + 1;

  logic [15:0]   hw_buf [BUF_HW];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_addr;
  logic [31:0]   inst_pc_q;
  logic          drop_lo;
  logic          squash;
  logic          outstanding;
  logic          run;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is32;
  logic          have;
  logic          pop;
  logic          req;
  logic          accept;
  logic          rsp;
  logic          push_lo;
  logic          push_hi;
  logic [CW-1:0] need;
  logic [CW-1:0] free;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Bit 0 of the redirect target is ignored by construction.
  logic unused_redirect_bit0;
  assign unused_redirect_bit0 = bus.redirect_pc[0];

  // Head decode and handshake qualifiers; redirect suppresses request and issue.
  always_comb begin
    h0      = hw_buf[rd_ptr];
    h1      = hw_buf[rd_ptr + PW'(1)];
    is32    = (h0[1:0] == 2'b11);
    need    = is32 ? CW'(2) : CW'(1);
    have    = (count != '0) && (count >= need);
    free    = CW'(BUF_HW) - count;
    req     = run && !outstanding && (free >= CW'(2)) && !bus.redirect;
    accept  = req && bus.imem_ready;
    rsp     = bus.imem_rvalid && outstanding;
    push_hi = rsp && !squash;
    push_lo = push_hi && !drop_lo;
    push_n  = CW'(push_lo) + CW'(push_hi);
    pop     = have && !bus.redirect && bus.inst_ready;
    pop_n   = pop ? need : '0;
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_addr;
  assign bus.inst_valid = have && !bus.redirect;
  assign bus.inst       = have ? (is32 ? {h1, h0} : {16'h0000, h0}) : 32'h0;
  assign bus.compflag   = have && is32;
  assign bus.inst_pc    = inst_pc_q;

  // Halfword storage; contents are only observed where count says they are valid.
  always_ff @(posedge clk) begin
    if (!bus.redirect) begin
      if (push_lo) hw_buf[wr_ptr] <= bus.imem_rdata[15:0];
      if (push_hi) hw_buf[push_lo ? wr_ptr + PW'(1) : wr_ptr] <= bus.imem_rdata[31:16];
    end
  end

  // Pointers, fetch address, PC and request/squash bookkeeping; redirect wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      inst_pc_q   <= RESET_PC;
      drop_lo     <= RESET_PC[1];
      squash      <= 1'b0;
      outstanding <= 1'b0;
      run         <= 1'b0;
    end else if (bus.redirect) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_addr  <= {bus.redirect_pc[31:2], 2'b00};
      inst_pc_q   <= {bus.redirect_pc[31:1], 1'b0};
      drop_lo     <= bus.redirect_pc[1];
      squash      <= outstanding && !rsp;
      outstanding <= outstanding && !rsp;
      run         <= 1'b1;
    end else begin
      run <= 1'b1;
      if (accept) begin
        fetch_addr  <= fetch_addr + 32'd4;
        outstanding <= 1'b1;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end
      if (rsp) begin
        squash <= 1'b0;
        if (!squash) drop_lo <= 1'b0;
      end
      wr_ptr    <= wr_ptr + PW'(push_n);
      rd_ptr    <= rd_ptr + PW'(pop_n);
      count     <= count + push_n - pop_n;
      inst_pc_q <= inst_pc_q + 32'({pop_n, 1'b0});
    end
  end
endmodule

// File: tb/tb_fetch_align_unit.sv
// Self-checking bench: memory model with latency, decode-side scoreboard.
module tb_fetch_align_unit;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  logic clk;
  logic rst;
  fetch_align_unit_if f();

  fetch_align_unit #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  bit ready_en = 1'b0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] acc_q     [$];
  exp_t        sb        [$];
  exp_t        obs       [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0001_0001;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = memword({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 2) == 0) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  // Instruction memory: accepts on req&ready, answers in order after mem_lat cycles.
  initial begin
    f.imem_ready  = 1'b0;
    f.imem_rvalid = 1'b0;
    f.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (f.imem_req && f.imem_ready) begin
        pend_addr.push_back(f.imem_addr);
        pend_due.push_back(cyc + mem_lat);
        acc_q.push_back(f.imem_addr);
      end
      @(posedge clk);
      cyc++;
      #1;
      f.imem_ready = ready_en;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        f.imem_rvalid = 1'b1;
        f.imem_rdata  = memword(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        f.imem_rvalid = 1'b0;
        f.imem_rdata  = 32'h0;
      end
    end
  end

  // Decode-side monitor: records every accepted instruction.
  always @(negedge clk) begin
    if (f.inst_valid && f.inst_ready) obs.push_back({f.inst, f.inst_pc, f.compflag});
  end

  // Reference model: walks memory halfwords from pc0 and queues n expected instructions.
  task automatic push_stream(input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    logic [15:0] lo;
    exp_t e;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      lo = hw_at(pc);
      if (lo[1:0] == 2'b11) begin
        e.inst = {hw_at(pc + 32'd2), lo};
        e.comp = 1'b1;
      end else begin
        e.inst = {16'h0000, lo};
        e.comp = 1'b0;
      end
      e.pc = pc;
      sb.push_back(e);
      pc = pc + (e.comp ? 32'd4 : 32'd2);
    end
  endtask

  // Scoreboard: pops each observed instruction against the expected queue.
  task automatic sb_compare();
    exp_t o;
    exp_t e;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL extra_inst: got inst=%h pc=%h comp=%b, required none", o.inst, o.pc, o.comp);
      end else begin
        e = sb.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          n_fail++;
          $display("FAIL inst_stream: got inst=%h pc=%h comp=%b, required inst=%h pc=%h comp=%b",
                   o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  // Drives inst_ready until every expected instruction has been seen (bounded).
  task automatic drain(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while (n < max_cyc) begin
      @(posedge clk);
      #1;
      sb_compare();
      if (sb.size() == 0) break;
      f.inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    f.inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_compare();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d instructions still expected after %0d cycles, required 0", sb.size(), max_cyc);
    end
  endtask

  task automatic apply_reset();
    ready_en     = 1'b0;
    f.inst_ready = 1'b0;
    f.redirect   = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50 && pend_addr.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    obs.delete();
    acc_q.delete();
    ready_en = 1'b1;
  endtask

  task automatic test_reset();
    ready_en      = 1'b0;
    f.inst_ready  = 1'b0;
    f.redirect    = 1'b0;
    f.redirect_pc = 32'h0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({f.imem_req, f.inst_valid, f.compflag} !== 3'b000 || f.inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b valid=%b comp=%b inst=%h, required 0 0 0 00000000",
               f.imem_req, f.inst_valid, f.compflag, f.inst);
    end
    n_checks++;
    if (f.imem_addr !== 32'h0 || f.inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got addr=%h pc=%h, required 00000000 00000000", f.imem_addr, f.inst_pc);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_release_cycle: got req=%b, required 0", f.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h, required 1 00000000", f.imem_req, f.imem_addr);
    end
  endtask

  task automatic test_rvc32();
    mem.delete();
    mem[32'h0] = 32'h0041_0113;
    mem_lat = 1;
    apply_reset();
    sb.push_back({32'h0041_0113, 32'h0, 1'b1});
    drain(50, 1'b0);
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) @(posedge clk);
    n_checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4) begin
      n_fail++;
      $display("FAIL second_req_addr: got %0d requests (second=%h), required second addr 00000004",
               acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_rvc_pair();
    mem.delete();
    mem[32'h0] = 32'h4505_4501;
    apply_reset();
    sb.push_back({32'h0000_4501, 32'h0, 1'b0});
    sb.push_back({32'h0000_4505, 32'h2, 1'b0});
    drain(50, 1'b0);
  endtask

  task automatic test_straddle();
    mem.delete();
    mem[32'h0] = 32'h0513_4501;
    mem[32'h4] = 32'h1234_00A0;
    mem_lat = 4;
    apply_reset();
    sb.push_back({32'h0000_4501, 32'h0, 1'b0});
    sb.push_back({32'h00A0_0513, 32'h2, 1'b1});
    f.inst_ready = 1'b1;
    for (int i = 0; i < 40 && obs.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (f.inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL straddle_hold: got inst_valid=%b with upper half pending, required 0", f.inst_valid);
    end
    drain(60, 1'b0);
    mem_lat = 1;
  endtask

  task automatic test_redirect();
    int i;
    mem.delete();
    mem[32'h0]   = 32'h4505_4501;
    mem[32'h4]   = 32'h4509_450D;
    mem[32'h8]   = 32'h0000_0000;
    mem[32'h100] = 32'h4589_0003;
    mem[32'h104] = 32'h0001_0613;
    mem_lat = 4;
    apply_reset();
    push_stream(32'h0, 4);
    f.inst_ready = 1'b1;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (f.imem_req && f.imem_ready && f.imem_addr == 32'h8) break;
    end
    n_checks++;
    if (i == 100) begin
      n_fail++;
      $display("FAIL redirect_setup: no request for 00000008 within 100 cycles, required one");
    end
    @(posedge clk);
    #1;
    f.redirect    = 1'b1;
    f.redirect_pc = 32'h0000_0102;
    @(negedge clk);
    n_checks++;
    if (f.inst_valid !== 1'b0 || f.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_cycle: got valid=%b req=%b, required 0 0", f.inst_valid, f.imem_req);
    end
    @(posedge clk);
    #1;
    f.redirect = 1'b0;
    sb_compare();
    sb.delete();
    push_stream(32'h0000_0102, 4);
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f.imem_req && f.imem_ready) break;
    end
    n_checks++;
    if (i == 40 || f.imem_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL redirect_addr: got addr=%h (waited %0d), required 00000100", f.imem_addr, i);
    end
    drain(200, 1'b1);
    mem_lat = 1;
  endtask

  task automatic test_backpressure();
    mem.delete();
    for (int i = 0; i < 8; i++)
      mem[32'(4 * i)] = {16'h4000 | 16'((2 * i + 1) << 2), 16'h4000 | 16'((2 * i) << 2)};
    apply_reset();
    repeat (14) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (f.imem_req !== 1'b0 || f.inst_valid !== 1'b1 || f.inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL full_stall: got req=%b valid=%b pc=%h, required 0 1 00000000",
               f.imem_req, f.inst_valid, f.inst_pc);
    end
    n_checks++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL full_fetches: got %0d word fetches while stalled, required 2", acc_q.size());
    end
    push_stream(32'h0, 10);
    drain(200, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int i;
    mem.delete();
    mem[32'h0] = 32'h0041_0113;
    mem[32'h4] = 32'h4505_4501;
    mem_lat = 5;
    apply_reset();
    push_stream(32'h0, 3);
    f.inst_ready = 1'b1;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (f.imem_req && f.imem_ready && f.imem_addr == 32'h4) break;
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ready_en = 1'b0;
    #1;
    n_checks++;
    if ({f.imem_req, f.inst_valid, f.compflag} !== 3'b000 || f.inst !== 32'h0 ||
        f.inst_pc !== 32'h0 || f.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midflight_reset: got req=%b valid=%b comp=%b inst=%h pc=%h addr=%h, required all 0",
               f.imem_req, f.inst_valid, f.compflag, f.inst, f.inst_pc, f.imem_addr);
    end
    sb_compare();
    sb.delete();
    f.inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (i = 0; i < 50 && pend_addr.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    obs.delete();
    ready_en = 1'b1;
    push_stream(32'h0, 3);
    drain(100, 1'b0);
    mem_lat = 1;
  endtask

  task automatic test_mixed_stream();
    mem.delete();
    for (int i = 0; i < 64; i++) mem[32'(4 * i)] = {rand_hw(), rand_hw()};
    mem_lat = 2;
    apply_reset();
    push_stream(32'h0, 40);
    drain(2000, 1'b1);
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_rvc32();
    test_rvc_pair();
    test_straddle();
    test_redirect();
    test_backpressure();
    test_reset_midflight();
    test_mixed_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_align_unit.md
Name: fetch_align_unit

Overview:
- Instruction-fetch front end that consumes the next-PC redirect produced by the PC control logic.
- Issues word-aligned requests to instruction memory and buffers returned halfwords.
- Realigns mixed 16-bit (RVC) and 32-bit instructions and presents one instruction per handshake to decode.
- Its compflag output drives the PC control logic's PC+2 / PC+4 selection.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be halfword-aligned.
- BUF_HW, 4: halfword buffer depth; must be a power of two, minimum 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- redirect  input  1  taken branch/JAL/JALR; flush and refetch
- redirect_pc  input  32  new PC; bit 0 ignored
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch word address; bits [1:0] always 0
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid; in order, at least 1 cycle after acceptance
- imem_rdata  input  32  read word; little-endian, low halfword at addr+0
- inst_valid  output  1  inst, inst_pc and compflag valid
- inst_ready  input  1  decode accepts the instruction
- inst  output  32  instruction; RVC instructions are zero-extended {16'h0, hw}
- inst_pc  output  32  address of inst
- compflag  output  1  1 = 32-bit instruction, 0 = 16-bit

Behaviour:
- Reset (async, any cycle): buffer empty, at most 0 outstanding requests, fetch_addr = {RESET_PC[31:2],2'b00}, drop_lo = RESET_PC[1], inst_pc = RESET_PC. Outputs: imem_req = 0, inst_valid = 0, inst = 0, compflag = 0.
- Outstanding limit: at most one request in flight.
- Request rule: imem_req = 1 when no request is outstanding and free slots ≥ 2.
  - Free-slot count excludes halfwords still to arrive.
  - First request possible the cycle after rst deasserts.
- Request transfer: occurs on imem_req & imem_ready.
  - fetch_addr += 4 (wraps at 2^32).
  - imem_addr holds stable while imem_req = 1 and imem_ready = 0.
- Response: on imem_rvalid, push low then high halfword.
  - If drop_lo = 1, push only the high halfword, then clear drop_lo.
  - If a squash is pending, discard the whole word and clear the squash.
- Decode of buffer head halfword h0:
  - h0[1:0] != 2'b11: 16-bit instruction, needs 1 halfword, compflag = 0.
  - h0[1:0] == 2'b11: 32-bit instruction, needs 2 halfwords, inst = {h1,h0}, compflag = 1.
- inst_valid = 1 when the buffer holds the required halfword count and redirect = 0. Output is combinational from the buffer head.
- Output transfer: on inst_valid & inst_ready, pop 1 or 2 halfwords; inst_pc += 2 or 4.
- A 32-bit instruction that straddles words (starts at addr[1] = 1) is held with inst_valid = 0 until its upper halfword arrives.
- A simultaneous push and pop in the same cycle is legal; the buffer never overflows, guaranteed by the free-slot rule.
- Redirect has highest priority over push, pop and request, and takes effect the same cycle:
  - Buffer cleared.
  - inst_pc = {redirect_pc[31:1],1'b0}.
  - fetch_addr = {redirect_pc[31:2],2'b00}.
  - drop_lo = redirect_pc[1].
  - If a request is outstanding or accepted this cycle, set squash.
  - imem_req is forced to 0 during the redirect cycle.
  - inst_valid is forced to 0, so no output transfer occurs.
- Back-to-back redirects: the last one wins; squash stays set until the single outstanding response is discarded.
- Squashed response and the next request: the new request may issue before the squashed response returns only if the outstanding limit allows it. With a limit of one it cannot, so the new request waits for the discard.
- Buffer pointers wrap modulo BUF_HW; the count is held separately so full and empty are distinguishable.

Test Plan:
- Reset release, RESET_PC = 0, memory returns 32'h0041_0113 at addr 0 → one 32-bit instruction: inst = 32'h0041_0113, inst_pc = 0, compflag = 1, then a request for addr 4.
- Word 32'h4505_4501 at 0 → two RVC instructions: inst = 32'h0000_4501 at pc 0, then 32'h0000_4505 at pc 2, both with compflag = 0.
- Straddle: word 0 = 32'h0513_4501, word 4 = 32'hxxxx_00A0 → RVC at pc 0, then 32'h00A0_0513 at pc 2 with compflag = 1. inst_valid stays 0 until word 4 returns.
- Redirect to 32'h0000_0102 while the response for addr 8 is outstanding → that response is discarded, next imem_addr = 32'h100, low halfword dropped, first inst_pc = 32'h102.
- Backpressure: inst_ready = 0 for 10 cycles → buffer fills to BUF_HW, imem_req drops to 0, no data lost; releasing inst_ready resumes in-order delivery.
- rst asserted mid-transfer with a response pending → all outputs zero immediately; the pending response after reset is ignored and fetch restarts at RESET_PC.
